// File: rtl/fpu_addsub_seq_pkg.sv
// pa_fpu: shared FPU operation codes, unpacked operand type, constants and sequencer states
package pa_fpu;
  typedef enum logic [2:0] {op_add, op_sub, op_mul, op_div} e_fpu_op;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
  } st_ieee_unpacked;
  typedef enum logic [2:0] {CLS_NORMAL, CLS_ZERO, CLS_SUB, CLS_INF, CLS_NAN} e_fpu_class;
  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_RESP} e_fpu_seq_state;
  localparam logic [31:0] FPU_QNAN = 32'h7fc00000;
  localparam int FPU_EXP_BIAS = 127;
endpackage

// File: rtl/fpu_unpack_classify.sv
// fpu_unpack_classify: split an IEEE-754 single into sign/exp/mant (subnormals get exp 1, hidden 0) and classify it
module fpu_unpack_classify
  import pa_fpu::*;
(
  input  logic [31:0]     ieee_i,
  output st_ieee_unpacked unp_o,
  output e_fpu_class      cls_o
);
  logic exp_zero, exp_ones, frac_zero;
  assign exp_zero  = ieee_i[30:23] == 8'h00;
  assign exp_ones  = ieee_i[30:23] == 8'hff;
  assign frac_zero = ieee_i[22:0] == 23'h0;
  assign unp_o     = {ieee_i[31], exp_zero ? 8'd1 : ieee_i[30:23], ~exp_zero, ieee_i[22:0]};
  assign cls_o     = exp_ones ? (frac_zero ? CLS_INF : CLS_NAN) :
                     exp_zero ? (frac_zero ? CLS_ZERO : CLS_SUB) : CLS_NORMAL;
endmodule

// File: rtl/fpu_addsub_seq.sv
// fpu_addsub_seq: multi-cycle handshaked IEEE-754 single add/sub (RNE); FPU_FLAGS_EN adds flags {invalid,overflow,underflow,inexact}
module fpu_addsub_seq
  import pa_fpu::*;
#(
  parameter int ALIGN_CLAMP = 26
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  e_fpu_op     operation,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] ieee_packet_out,
  output logic        op_error
`ifdef FPU_FLAGS_EN
  ,
  output logic [3:0]  flags
`endif
);
  e_fpu_seq_state  state_q, state_d;
  e_fpu_op         op_q, op_d;
  logic [31:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic            sa_q, sa_d, sb_q, sb_d, err_q, err_d;
  logic [9:0]      exp_q, exp_d, exp_fin;
  logic [27:0]     m_q, m_d;
  logic [26:0]     mb_q, mb_d;
  logic [7:0]      cnt_q, cnt_d, diff;
  st_ieee_unpacked ua, ub, ub_e, hi, lo;
  e_fpu_class      ca, cb;
  logic            swap, inf_inf, rnd_up, ovf;
  logic [24:0]     mr;
  logic [23:0]     m_fin;
`ifdef FPU_FLAGS_EN
  logic [3:0]      flg_q, flg_d;
  assign flags = flg_q;
`endif

  fpu_unpack_classify u_ua (.ieee_i(a_q), .unp_o(ua), .cls_o(ca));
  fpu_unpack_classify u_ub (.ieee_i(b_q), .unp_o(ub), .cls_o(cb));

  assign ub_e    = {ub.sign ^ (op_q == op_sub), ub.exp, ub.mant};
  assign swap    = b_q[30:0] > a_q[30:0];
  assign hi      = swap ? ub_e : ua;
  assign lo      = swap ? ua : ub_e;
  assign diff    = hi.exp - lo.exp;
  assign inf_inf = ca == CLS_INF && cb == CLS_INF && ua.sign != ub_e.sign;
  assign rnd_up  = m_q[2] & (m_q[3] | m_q[1] | m_q[0]);
  assign mr      = {1'b0, m_q[26:3]} + {24'd0, rnd_up};
  assign m_fin   = mr[24] ? mr[24:1] : mr[23:0];
  assign exp_fin = exp_q + {9'd0, mr[24]};
  assign ovf     = exp_fin >= 10'(2 * FPU_EXP_BIAS + 1);

  assign req_ready       = state_q == S_IDLE;
  assign resp_valid      = state_q == S_RESP;
  assign ieee_packet_out = res_q;
  assign op_error        = err_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    err_d   = err_q;
    exp_d   = exp_q;
    m_d     = m_q;
    mb_d    = mb_q;
    cnt_d   = cnt_q;
`ifdef FPU_FLAGS_EN
    flg_d   = flg_q;
`endif
    case (state_q)
      S_IDLE: if (req_valid) begin
        a_d     = a_operand;
        b_d     = b_operand;
        op_d    = operation;
        err_d   = 1'b0;
`ifdef FPU_FLAGS_EN
        flg_d   = '0;
`endif
        state_d = S_UNPACK;
      end
      S_UNPACK: begin
        state_d = S_RESP;
        if (!(op_q inside {op_add, op_sub})) begin
          res_d = '0;
          err_d = 1'b1;
        end else if (ca == CLS_NAN || cb == CLS_NAN || inf_inf) begin
          res_d = FPU_QNAN;
`ifdef FPU_FLAGS_EN
          flg_d = 4'b1000;
`endif
        end else if (ca == CLS_INF || cb == CLS_INF) begin
          res_d = {ca == CLS_INF ? ua.sign : ub_e.sign, 8'hff, 23'd0};
        end else begin
          state_d = diff == 8'd0 ? S_ADD : S_ALIGN;
          sa_d    = hi.sign;
          sb_d    = lo.sign;
          exp_d   = {2'b00, hi.exp};
          m_d     = {1'b0, hi.mant, 3'b000};
          mb_d    = {lo.mant, 3'b000};
          cnt_d   = diff > 8'(ALIGN_CLAMP) ? 8'(ALIGN_CLAMP) : diff;
        end
      end
      S_ALIGN: begin
        mb_d    = {1'b0, mb_q[26:2], mb_q[1] | mb_q[0]};
        cnt_d   = cnt_q - 8'd1;
        state_d = cnt_q == 8'd1 ? S_ADD : S_ALIGN;
      end
      S_ADD: begin
        m_d     = sa_q == sb_q ? m_q + {1'b0, mb_q} : m_q - {1'b0, mb_q};
        state_d = S_NORM;
      end
      S_NORM: begin
        if (m_q == 28'd0) begin
          res_d   = {sa_q & sb_q, 31'd0};
          state_d = S_RESP;
        end else if (m_q[27]) begin
          m_d     = {1'b0, m_q[27:2], m_q[1] | m_q[0]};
          exp_d   = exp_q + 10'd1;
          state_d = S_ROUND;
        end else if (!m_q[26] && exp_q > 10'd1) begin
          m_d     = m_q << 1;
          exp_d   = exp_q - 10'd1;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        res_d   = ovf ? {sa_q, 8'hff, 23'd0} : {sa_q, m_fin[23] ? exp_fin[7:0] : 8'd0, m_fin[22:0]};
`ifdef FPU_FLAGS_EN
        flg_d   = {1'b0, ovf, ~m_q[26] & (|m_q[2:0]), ovf | (|m_q[2:0])};
`endif
        state_d = S_RESP;
      end
      S_RESP: state_d = resp_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      op_q    <= op_add;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      err_q   <= 1'b0;
      exp_q   <= '0;
      m_q     <= '0;
      mb_q    <= '0;
      cnt_q   <= '0;
`ifdef FPU_FLAGS_EN
      flg_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      err_q   <= err_d;
      exp_q   <= exp_d;
      m_q     <= m_d;
      mb_q    <= mb_d;
      cnt_q   <= cnt_d;
`ifdef FPU_FLAGS_EN
      flg_q   <= flg_d;
`endif
    end
  end
endmodule

// File: tb/tb_fpu_addsub_seq.sv
// tb_fpu_addsub_seq: directed-vector self-checking bench for fpu_addsub_seq
module tb_fpu_addsub_seq;
  import pa_fpu::*;
  logic        clk, arst_n, req_valid, req_ready, resp_valid, resp_ready, op_error, bad;
  logic [31:0] a_operand, b_operand, ieee_packet_out;
  e_fpu_op     operation;
  int          nvec = 0, nerr = 0;
`ifdef FPU_FLAGS_EN
  logic [3:0]  flags;
`endif

  fpu_addsub_seq dut (
    .clk(clk), .arst_n(arst_n), .req_valid(req_valid), .req_ready(req_ready),
    .a_operand(a_operand), .b_operand(b_operand), .operation(operation),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .ieee_packet_out(ieee_packet_out), .op_error(op_error)
`ifdef FPU_FLAGS_EN
    , .flags(flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [34:0] got, input logic [34:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input e_fpu_op op, input logic [32:0] want, input int hold);
    int n = 0;
    @(negedge clk);
    a_operand = a;
    b_operand = b;
    operation = op;
    req_valid = 1'b1;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    a_operand = $urandom;
    b_operand = $urandom;
    operation = op_div;
    n = 0;
    while (!resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold"}, {req_ready, resp_valid, op_error, ieee_packet_out}, {2'b01, want});
      @(negedge clk);
    end
    chk(tag, {req_ready, resp_valid, op_error, ieee_packet_out}, {2'b01, want});
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    arst_n = 1'b0;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    a_operand = '0;
    b_operand = '0;
    operation = op_add;
    repeat (2) @(negedge clk);
    chk("rst_hold", {req_ready, resp_valid, op_error, ieee_packet_out}, {3'b100, 32'h0});
    arst_n = 1'b1;
    @(negedge clk);
    chk("rst_release", {req_ready, resp_valid, op_error, ieee_packet_out}, {3'b100, 32'h0});

    vec("add_1_1p1", 32'h3f800000, 32'h3f8ccccd, op_add, {1'b0, 32'h40066666}, 5);
    vec("sub_1_1p1", 32'h3f800000, 32'h3f8ccccd, op_sub, {1'b0, 32'hbdccccd0}, 0);
    vec("inf_sub_inf", 32'h7f800000, 32'h7f800000, op_sub, {1'b0, 32'h7fc00000}, 0);
    vec("ninf_add_inf", 32'hff800000, 32'h7f800000, op_add, {1'b0, 32'h7fc00000}, 0);
    vec("nan_in", 32'h402df854, 32'h7fc00000, op_add, {1'b0, 32'h7fc00000}, 0);
    vec("ninf_sub_1", 32'hff800000, 32'h3f800000, op_sub, {1'b0, 32'hff800000}, 0);
    vec("1_sub_inf", 32'h3f800000, 32'h7f800000, op_sub, {1'b0, 32'hff800000}, 0);
    vec("sub_to_norm", 32'h007fffff, 32'h00000001, op_add, {1'b0, 32'h00800000}, 0);
    vec("tiny_sub_self", 32'h00000001, 32'h00000001, op_sub, {1'b0, 32'h00000000}, 0);
    vec("tiny_cancel", 32'h80000001, 32'h00000001, op_add, {1'b0, 32'h00000000}, 0);
    vec("nz_add_nz", 32'h80000000, 32'h80000000, op_add, {1'b0, 32'h80000000}, 0);
    vec("pz_sub_pz", 32'h00000000, 32'h00000000, op_sub, {1'b0, 32'h00000000}, 0);
    vec("16_sub_32", 32'h41800000, 32'h42000000, op_sub, {1'b0, 32'hc1800000}, 0);
    vec("2_sub_1", 32'h40000000, 32'h3f800000, op_sub, {1'b0, 32'h3f800000}, 0);
    vec("x_add_zero", 32'h42168f5c, 32'h00000000, op_add, {1'b0, 32'h42168f5c}, 0);
    vec("sticky_up", 32'h3f800000, 32'h33800001, op_add, {1'b0, 32'h3f800001}, 0);
    vec("below_half", 32'h3f800000, 32'h33000001, op_add, {1'b0, 32'h3f800000}, 0);
    vec("clamp_gt26", 32'h3f800000, 32'h30000000, op_add, {1'b0, 32'h3f800000}, 0);
    vec("tie_even", 32'h3f800000, 32'h33800000, op_add, {1'b0, 32'h3f800000}, 0);
    vec("tie_odd", 32'h3f800001, 32'h33800000, op_add, {1'b0, 32'h3f800002}, 0);
    vec("round_carry", 32'h3fffffff, 32'h33800000, op_add, {1'b0, 32'h40000000}, 0);
    vec("overflow", 32'h7f7fffff, 32'h7f7fffff, op_add, {1'b0, 32'h7f800000}, 0);
    vec("bad_op", 32'h3f800000, 32'h3f800000, op_mul, {1'b1, 32'h00000000}, 0);

    @(negedge clk);
    a_operand = 32'h3f800000;
    b_operand = 32'h3f800000;
    operation = op_add;
    req_valid = 1'b1;
    @(negedge clk);
    a_operand = 32'h40000000;
    b_operand = 32'h40000000;
    bad = 1'b0;
    for (int n = 0; n < 100 && !resp_valid; n++) begin
      if (req_ready) bad = 1'b1;
      @(negedge clk);
    end
    if (req_ready) bad = 1'b1;
    chk("b2b_first", {req_ready, resp_valid, op_error, ieee_packet_out}, {3'b010, 32'h40000000});
    chk("b2b_busy", {34'd0, bad}, 35'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("b2b_idle", {34'd0, req_ready}, 35'd1);
    @(negedge clk);
    req_valid = 1'b0;
    a_operand = $urandom;
    b_operand = $urandom;
    for (int n = 0; n < 100 && !resp_valid; n++) @(negedge clk);
    chk("b2b_second", {req_ready, resp_valid, op_error, ieee_packet_out}, {3'b010, 32'h40800000});
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    @(negedge clk);
    a_operand = 32'h3f800000;
    b_operand = 32'h30000000;
    operation = op_add;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk("rst_mid_low", {req_ready, resp_valid, op_error, ieee_packet_out}, {3'b100, 32'h0});
    @(negedge clk);
    arst_n = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid || !req_ready) bad = 1'b1;
    end
    chk("rst_mid_quiet", {34'd0, bad}, 35'd0);
    vec("post_rst", 32'h3f800000, 32'h3f800000, op_add, {1'b0, 32'h40000000}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
